egress_reader: RTL and testbench

- Host-side read path of the packet switch, and the return direction of the Avalon-MM write path that loads the ingress FIFOs.
- Buffers bytes leaving the three crossbar output ports in three internal queues.
- Software drains the queues through an 8-bit Avalon-MM slave and reads status, levels and a drop counter.
- Also provides per-queue interrupt masking and flush.

---
 rtl/egress_reader.sv | 138 +++++++++++++
 tb/tb_egress_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/egress_reader.sv
// egress_reader: three egress byte queues fed by the crossbar output ports,
// drained by software through an 8-bit Avalon-MM slave with status, level,
// drop counter, interrupt mask and per-queue flush registers.
module egress_reader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipselect,
  input  logic       read,
  input  logic       write,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [2:0] in_valid,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  output logic [2:0] in_ready,
  output logic       irq
);

  logic [7:0]  in_data [3];
  logic [AW:0] level   [3];
  logic [7:0]  head    [3];

  logic [2:0]  full, empty, push, pop, drop, flush;
  logic        rd_acc, wr_acc;
  logic        clr_drop;
  logic [2:0]  irq_mask;
  logic [7:0]  drop_cnt;
  logic        overflow;
  logic [7:0]  rd_mux;
  logic [1:0]  n_drop;
  logic [8:0]  drop_sum;
  logic [7:0]  drop_nxt;
  logic        overflow_nxt;
  logic        unused_wdata;

  assign in_data[0] = in_data1;
  assign in_data[1] = in_data2;
  assign in_data[2] = in_data3;

  // A simultaneous read and write is treated as a read only.
  assign rd_acc   = chipselect & read;
  assign wr_acc   = chipselect & write & ~read;
  assign clr_drop = wr_acc && (address == 3'd7);

  assign unused_wdata = ^writedata[7:3];

  for (genvar q = 0; q < 3; q++) begin : g_queue
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   lvl;

    assign level[q] = lvl;
    assign head[q]  = mem[rd_ptr];
    assign full[q]  = (lvl == (AW+1)'(DEPTH));
    assign empty[q] = (lvl == '0);
    assign flush[q] = wr_acc && (address == 3'(q + 1));
    assign pop[q]   = rd_acc && (address == 3'(q + 1)) && !empty[q];
    // Full is judged on pre-edge state, so a same-cycle pop cannot make room;
    // a flush swallows the push without counting it as a drop.
    assign push[q]  = in_valid[q] && !full[q] && !flush[q];
    assign drop[q]  = in_valid[q] &&  full[q] && !flush[q];

    // Queue storage: write the incoming byte at the tail.
    always_ff @(posedge clk) begin
      if (push[q]) mem[wr_ptr] <= in_data[q];
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl    <= '0;
      end else if (flush[q]) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl    <= '0;
      end else begin
        if (push[q]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[q])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[q], pop[q]})
          2'b10:   lvl <= lvl + 1'b1;
          2'b01:   lvl <= lvl - 1'b1;
          default: lvl <= lvl;
        endcase
      end
    end
  end

  // Drop accounting: several ports may drop in one cycle; a same-cycle clear
  // restarts the count from those drops.
  always_comb begin
    n_drop       = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    drop_sum     = {1'b0, (clr_drop ? 8'h00 : drop_cnt)} + 9'(n_drop);
    drop_nxt     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_nxt = (clr_drop ? 1'b0 : overflow) | (|drop);
  end

  // Read data selection from pre-edge state.
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = {1'b0, overflow, full, ~empty};
      3'd1: rd_mux = empty[0] ? 8'h00 : head[0];
      3'd2: rd_mux = empty[1] ? 8'h00 : head[1];
      3'd3: rd_mux = empty[2] ? 8'h00 : head[2];
      3'd4: rd_mux = 8'(level[0]);
      3'd5: rd_mux = 8'(level[1]);
      3'd6: rd_mux = 8'(level[2]);
      3'd7: rd_mux = drop_cnt;
      default: rd_mux = '0;
    endcase
  end

  // Control registers and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= '0;
      irq_mask <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (rd_acc) readdata <= rd_mux;
      if (wr_acc && (address == 3'd0)) irq_mask <= writedata[2:0];
      drop_cnt <= drop_nxt;
      overflow <= overflow_nxt;
    end
  end

  assign in_ready = ~full;
  assign irq      = |(irq_mask & ~empty);

endmodule

// File: tb/tb_egress_reader.sv
// Directed bench for egress_reader: a vector table of single-cycle bus/push
// operations with expected results, followed by multi-cycle sequences for
// pointer wrap, drop-counter saturation and asynchronous reset.
module tb_egress_reader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [2:0] address = '0;
  logic [7:0] writedata = '0;
  logic [7:0] readdata;
  logic [2:0] in_valid = '0;
  logic [7:0] in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [2:0] in_ready;
  logic       irq;

  egress_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .in_valid(in_valid), .in_data1(in_data1),
    .in_data2(in_data2), .in_data3(in_data3), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [2:0] vld;
    logic [7:0] d1, d2, d3;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic [2:0] exp_rdy;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] sb[$];

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [2:0] addr,
                     input logic [7:0] wdata, input logic [2:0] vld,
                     input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                     input logic chk, input logic [7:0] exp,
                     input logic [2:0] rdy, input logic irqv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.vld = vld;
    v.d1 = d1; v.d2 = d2; v.d3 = d3; v.chk_rd = chk; v.exp_rd = exp;
    v.exp_rdy = rdy; v.exp_irq = irqv;
    vecs.push_back(v);
  endtask

  task automatic vrd(input logic [2:0] a, input logic [7:0] exp, input logic [2:0] rdy, input logic irqv);
    add(1'b1, 1'b0, a, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, exp, rdy, irqv);
  endtask

  task automatic vpush(input logic [2:0] vld, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic [2:0] rdy, input logic irqv);
    add(1'b0, 1'b0, 3'd0, 8'h00, vld, d1, d2, d3, 1'b0, 8'h00, rdy, irqv);
  endtask

  task automatic vwr(input logic [2:0] a, input logic [7:0] wd, input logic [2:0] vld,
                     input logic [7:0] d1, input logic [2:0] rdy, input logic irqv);
    add(1'b0, 1'b1, a, wd, vld, d1, 8'h00, 8'h00, 1'b0, 8'h00, rdy, irqv);
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    in_valid = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic drive(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [7:0] wd, input logic [2:0] vld,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    chipselect = rd | wr; read = rd; write = wr; address = a; writedata = wd;
    in_valid = vld; in_data1 = d1; in_data2 = d2; in_data3 = d3;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    drive(1'b1, 1'b0, a, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    check8(nm, readdata, exp);
  endtask

  function automatic logic [7:0] wrap_byte(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    // ---------------- vector table ----------------
    vrd(3'd0, 8'h00, 3'b111, 1'b0);
    vpush(3'b010, 8'h00, 8'h11, 8'h00, 3'b111, 1'b0);
    vpush(3'b010, 8'h00, 8'h22, 8'h00, 3'b111, 1'b0);
    vpush(3'b010, 8'h00, 8'h33, 8'h00, 3'b111, 1'b0);
    vrd(3'd5, 8'h03, 3'b111, 1'b0);
    vrd(3'd2, 8'h11, 3'b111, 1'b0);
    vrd(3'd2, 8'h22, 3'b111, 1'b0);
    vrd(3'd2, 8'h33, 3'b111, 1'b0);
    vrd(3'd2, 8'h00, 3'b111, 1'b0);
    vrd(3'd5, 8'h00, 3'b111, 1'b0);
    vrd(3'd0, 8'h00, 3'b111, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      vpush(3'b001, 8'(8'hA0 + i), 8'h00, 8'h00, (i >= DEPTH - 1) ? 3'b110 : 3'b111, 1'b0);
    vrd(3'd0, 8'h49, 3'b110, 1'b0);
    vrd(3'd4, 8'h10, 3'b110, 1'b0);
    vrd(3'd7, 8'h02, 3'b110, 1'b0);
    vwr(3'd7, 8'h00, 3'b000, 8'h00, 3'b110, 1'b0);
    vrd(3'd7, 8'h00, 3'b110, 1'b0);
    vrd(3'd0, 8'h09, 3'b110, 1'b0);
    vrd(3'd1, 8'hA0, 3'b111, 1'b0);
    vrd(3'd4, 8'h0F, 3'b111, 1'b0);
    add(1'b1, 1'b0, 3'd1, 8'h00, 3'b001, 8'hB0, 8'h00, 8'h00, 1'b1, 8'hA1, 3'b111, 1'b0);
    vrd(3'd4, 8'h0F, 3'b111, 1'b0);
    vwr(3'd1, 8'h00, 3'b000, 8'h00, 3'b111, 1'b0);
    vrd(3'd4, 8'h00, 3'b111, 1'b0);
    vrd(3'd0, 8'h00, 3'b111, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      vpush(3'b001, 8'(8'hC0 + i), 8'h00, 8'h00, (i == DEPTH - 1) ? 3'b110 : 3'b111, 1'b0);
    vwr(3'd7, 8'h00, 3'b001, 8'hFF, 3'b110, 1'b0);
    vrd(3'd7, 8'h01, 3'b110, 1'b0);
    vrd(3'd0, 8'h49, 3'b110, 1'b0);
    vwr(3'd1, 8'h00, 3'b000, 8'h00, 3'b111, 1'b0);
    vwr(3'd7, 8'h00, 3'b000, 8'h00, 3'b111, 1'b0);
    vrd(3'd7, 8'h00, 3'b111, 1'b0);
    vrd(3'd0, 8'h00, 3'b111, 1'b0);
    vwr(3'd0, 8'h04, 3'b000, 8'h00, 3'b111, 1'b0);
    vpush(3'b001, 8'h55, 8'h00, 8'h00, 3'b111, 1'b0);
    vpush(3'b100, 8'h00, 8'h00, 8'h66, 3'b111, 1'b1);
    vrd(3'd0, 8'h05, 3'b111, 1'b1);
    vrd(3'd3, 8'h66, 3'b111, 1'b0);
    add(1'b1, 1'b1, 3'd0, 8'h07, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 3'b111, 1'b0);
    for (int i = 0; i < 4; i++)
      vpush(3'b001, 8'(8'h56 + i), 8'h00, 8'h00, 3'b111, 1'b0);
    vrd(3'd4, 8'h05, 3'b111, 1'b0);
    vwr(3'd1, 8'h00, 3'b001, 8'h77, 3'b111, 1'b0);
    vrd(3'd4, 8'h00, 3'b111, 1'b0);
    vrd(3'd7, 8'h00, 3'b111, 1'b0);
    vrd(3'd1, 8'h00, 3'b111, 1'b0);

    // ---------------- reset state ----------------
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check8("reset readdata", readdata, 8'h00);
    check8("reset in_ready", {5'b0, in_ready}, 8'h07);
    check8("reset irq", {7'b0, irq}, 8'h00);
    reset = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].vld,
            vecs[i].d1, vecs[i].d2, vecs[i].d3);
      if (vecs[i].chk_rd)
        check8($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      check8($sformatf("vec%0d in_ready", i), {5'b0, in_ready}, {5'b0, vecs[i].exp_rdy});
      check8($sformatf("vec%0d irq", i), {7'b0, irq}, {7'b0, vecs[i].exp_irq});
    end

    // ---------------- pointer wrap on port 3, at most 10 outstanding ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'b100, 8'h00, 8'h00, wrap_byte(i));
      sb.push_back(wrap_byte(i));
    end
    check8("wrap irq nonempty", {7'b0, irq}, 8'h01);
    do_rd(3'd6, 8'h0A, "wrap level prefill");
    for (int i = 10; i < 40; i++) begin
      logic [7:0] exp;
      drive(1'b1, 1'b0, 3'd3, 8'h00, 3'b100, 8'h00, 8'h00, wrap_byte(i));
      exp = sb.pop_front();
      sb.push_back(wrap_byte(i));
      check8($sformatf("wrap pop %0d", i - 10), readdata, exp);
    end
    do_rd(3'd6, 8'h0A, "wrap level steady");
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp;
      exp = sb.pop_front();
      do_rd(3'd3, exp, $sformatf("wrap drain %0d", i));
    end
    do_rd(3'd6, 8'h00, "wrap level drained");
    check8("wrap irq empty", {7'b0, irq}, 8'h00);

    // ---------------- drop counter saturation on port 2 ----------------
    for (int i = 0; i < DEPTH + 260; i++)
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'b010, 8'h00, 8'(i), 8'h00);
    check8("sat in_ready", {5'b0, in_ready}, 8'h05);
    do_rd(3'd7, 8'hFF, "sat drop count");
    do_rd(3'd0, 8'h52, "sat status");
    drive(1'b0, 1'b1, 3'd2, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 3'd7, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00);
    do_rd(3'd7, 8'h00, "sat cleared");

    // ---------------- asynchronous reset mid-burst ----------------
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'b100, 8'h00, 8'h00, 8'h99);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'b001, 8'(i), 8'h00, 8'h00);
    do_rd(3'd0, 8'h0D, "pre-reset status");
    check8("pre-reset in_ready", {5'b0, in_ready}, 8'h06);
    check8("pre-reset irq", {7'b0, irq}, 8'h01);
    in_valid = 3'b011; in_data1 = 8'hEE; in_data2 = 8'hDD;
    @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    check8("async reset readdata", readdata, 8'h00);
    check8("async reset in_ready", {5'b0, in_ready}, 8'h07);
    check8("async reset irq", {7'b0, irq}, 8'h00);
    @(posedge clk);
    #1;
    check8("held reset in_ready", {5'b0, in_ready}, 8'h07);
    idle();
    reset = 1'b1;
    do_rd(3'd0, 8'h00, "post-reset status");
    do_rd(3'd4, 8'h00, "post-reset level1");
    do_rd(3'd5, 8'h00, "post-reset level2");
    do_rd(3'd6, 8'h00, "post-reset level3");
    do_rd(3'd7, 8'h00, "post-reset drops");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
